// File: rtl/copper_pkg.sv
// Shared definitions for the video copper: command-list entry layout,
// opcodes and sequencer state encoding.
package copper_pkg;

    localparam logic [1:0] OP_WAIT  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_END   = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // Entry layout: [15:14] op, [13:12] reserved, [11:8] reg addr, [7:0] data/line
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 14;
    localparam int REG_HI = 11;
    localparam int REG_LO = 8;
    localparam int DAT_HI = 7;
    localparam int DAT_LO = 0;

    localparam int ENTRY_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_WAIT,
        ST_WRITE
    } copper_state_t;

endpackage

// File: rtl/copper_list_ram.sv
// Command list storage: true dual-port RAM on one clock. Port A is the CPU
// read/write port, port B is the sequencer read port; both reads are registered.
module copper_list_ram
    import copper_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic               clk,
    input  logic [AW-1:0]      a_addr,
    input  logic [ENTRY_W-1:0] a_wrdata,
    input  logic               a_wren,
    output logic [ENTRY_W-1:0] a_rddata,
    input  logic [AW-1:0]      b_addr,
    output logic [ENTRY_W-1:0] b_rddata
);

    logic [ENTRY_W-1:0] mem [2**AW];

    // Reads return the contents from before a same-cycle write (read-old).
    always_ff @(posedge clk) begin
        if (a_wren) begin
            mem[a_addr] <= a_wrdata;
        end
        a_rddata <= mem[a_addr];
        b_rddata <= mem[b_addr];
    end

endmodule

// File: rtl/video_copper.sv
// Raster-synchronous register sequencer: runs a CPU-loaded command list each
// frame and shares the video IO port with the CPU, which always has priority.
module video_copper
    import copper_pkg::*;
#(
    parameter int LIST_AW = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               newframe,
    input  logic [7:0]         vline,
    input  logic               cpu_io_sel,
    input  logic [3:0]         cpu_io_addr,
    input  logic [7:0]         cpu_io_wrdata,
    input  logic               cpu_io_wren,
    output logic [3:0]         io_addr,
    output logic [7:0]         io_wrdata,
    output logic               io_wren,
    input  logic [LIST_AW-1:0] lst_addr,
    input  logic [15:0]        lst_wrdata,
    input  logic               lst_wren,
    output logic [15:0]        lst_rddata,
    output logic               busy,
    output logic [LIST_AW-1:0] pc
);

    localparam logic [LIST_AW-1:0] PC_LAST = '1;

    copper_state_t      state, state_nx;
    logic [LIST_AW-1:0] pc_nx;
    logic [15:0]        entry, entry_nx;
    logic [15:0]        list_rd;
    logic               copper_wr;
    logic               unused_rsvd;

    copper_list_ram #(
        .AW(LIST_AW)
    ) u_list_ram (
        .clk      (clk),
        .a_addr   (lst_addr),
        .a_wrdata (lst_wrdata),
        .a_wren   (lst_wren),
        .a_rddata (lst_rddata),
        .b_addr   (pc),
        .b_rddata (list_rd)
    );

    assign unused_rsvd = ^{list_rd[13:12], entry[15:12]};
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            pc    <= '0;
            entry <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            entry <= entry_nx;
        end
    end

    // newframe and enable override the sequence, so a stalled WRITE is simply
    // abandoned rather than issued on its way out.
    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        entry_nx  = entry;
        copper_wr = 1'b0;
        if (newframe) begin
            pc_nx    = '0;
            state_nx = enable ? ST_FETCH : ST_IDLE;
        end else if (!enable) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_FETCH: begin
                    state_nx = ST_DECODE;
                end
                ST_DECODE: begin
                    entry_nx = list_rd;
                    case (list_rd[OP_HI:OP_LO])
                        OP_WAIT:  state_nx = ST_WAIT;
                        OP_WRITE: state_nx = ST_WRITE;
                        default:  state_nx = ST_IDLE;
                    endcase
                end
                ST_WAIT: begin
                    // vline 255 (vblank) compares >= every line value
                    if (vline >= entry[DAT_HI:DAT_LO]) begin
                        if (pc == PC_LAST) begin
                            state_nx = ST_IDLE;
                        end else begin
                            pc_nx    = pc + 1'b1;
                            state_nx = ST_FETCH;
                        end
                    end
                end
                ST_WRITE: begin
                    if (!cpu_io_sel) begin
                        copper_wr = 1'b1;
                        if (pc == PC_LAST) begin
                            state_nx = ST_IDLE;
                        end else begin
                            pc_nx    = pc + 1'b1;
                            state_nx = ST_FETCH;
                        end
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        io_addr   = cpu_io_addr;
        io_wrdata = cpu_io_wrdata;
        io_wren   = 1'b0;
        if (cpu_io_sel) begin
            io_wren = cpu_io_wren;
        end else if (copper_wr) begin
            io_addr   = entry[REG_HI:REG_LO];
            io_wrdata = entry[DAT_HI:DAT_LO];
            io_wren   = 1'b1;
        end
    end

endmodule

// File: tb/tb_video_copper.sv
// Self-checking bench for video_copper: bus-mux vector table plus frame
// sequences, with copper IO writes checked against a scoreboard queue.
module tb_video_copper;

    localparam int LIST_AW = 6;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               enable;
    logic               newframe;
    logic [7:0]         vline;
    logic               cpu_io_sel;
    logic [3:0]         cpu_io_addr;
    logic [7:0]         cpu_io_wrdata;
    logic               cpu_io_wren;
    logic [3:0]         io_addr;
    logic [7:0]         io_wrdata;
    logic               io_wren;
    logic [LIST_AW-1:0] lst_addr;
    logic [15:0]        lst_wrdata;
    logic               lst_wren;
    logic [15:0]        lst_rddata;
    logic               busy;
    logic [LIST_AW-1:0] pc;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic        sel;
        logic [3:0]  addr;
        logic [7:0]  data;
        logic        wren;
        logic [12:0] expect_io;
    } vec_t;

    wr_t  sb_q[$];
    vec_t vecs[6];
    int   errors   = 0;
    int   checks   = 0;
    int   wr_count = 0;

    always #5 clk = ~clk;

    video_copper #(
        .LIST_AW(LIST_AW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .newframe      (newframe),
        .vline         (vline),
        .cpu_io_sel    (cpu_io_sel),
        .cpu_io_addr   (cpu_io_addr),
        .cpu_io_wrdata (cpu_io_wrdata),
        .cpu_io_wren   (cpu_io_wren),
        .io_addr       (io_addr),
        .io_wrdata     (io_wrdata),
        .io_wren       (io_wren),
        .lst_addr      (lst_addr),
        .lst_wrdata    (lst_wrdata),
        .lst_wren      (lst_wren),
        .lst_rddata    (lst_rddata),
        .busy          (busy),
        .pc            (pc)
    );

    function automatic logic [15:0] e_write(input logic [3:0] a, input logic [7:0] d);
        return {2'b01, 2'b00, a, d};
    endfunction

    function automatic logic [15:0] e_wait(input logic [7:0] line);
        return {2'b00, 2'b00, 4'h0, line};
    endfunction

    localparam logic [15:0] E_END = 16'h8000;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic sel, input logic [3:0] a,
                                 input logic [7:0] d, input logic w);
        cpu_io_sel    = sel;
        cpu_io_addr   = a;
        cpu_io_wrdata = d;
        cpu_io_wren   = w;
    endtask

    task automatic loadEntry(input int idx, input logic [15:0] val);
        lst_addr   = idx[LIST_AW-1:0];
        lst_wrdata = val;
        lst_wren   = 1'b1;
        tick();
        lst_wren   = 1'b0;
    endtask

    task automatic pulseNewframe;
        newframe = 1'b1;
        tick();
        newframe = 1'b0;
    endtask

    task automatic pushExpect(input logic [3:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        sb_q.push_back(w);
    endtask

    task automatic waitCopperWrite(input int budget, output int n);
        n = 0;
        while (!(io_wren && !cpu_io_sel) && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic waitIdle(input int budget, output int n);
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic waitWrites(input int target, input int budget);
        int n;
        n = 0;
        while (wr_count < target && n < budget) begin
            tick();
            n++;
        end
    endtask

    // Any copper write (io_wren with CPU idle) must match the head of the scoreboard.
    always @(negedge clk) begin
        if (io_wren && !cpu_io_sel) begin
            wr_t got;
            wr_t exp;
            wr_count++;
            got.addr = io_addr;
            got.data = io_wrdata;
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_copper_write", {20'h0, got}, 32'hFFFF_FFFF);
            end else begin
                exp = sb_q.pop_front();
                checkOutput("copper_write", {20'h0, got}, {20'h0, exp});
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int base;

        reset_n  = 1'b0;
        enable   = 1'b0;
        newframe = 1'b0;
        vline    = 8'd0;
        lst_addr = '0;
        lst_wrdata = '0;
        lst_wren = 1'b0;
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0);

        vecs[0] = '{1'b1, 4'h5, 8'h3C, 1'b1, {4'h5, 8'h3C, 1'b1}};
        vecs[1] = '{1'b1, 4'h9, 8'hA5, 1'b0, {4'h9, 8'hA5, 1'b0}};
        vecs[2] = '{1'b0, 4'h2, 8'h77, 1'b1, {4'h2, 8'h77, 1'b0}};
        vecs[3] = '{1'b0, 4'hF, 8'hFF, 1'b0, {4'hF, 8'hFF, 1'b0}};
        vecs[4] = '{1'b1, 4'h0, 8'h00, 1'b1, {4'h0, 8'h00, 1'b1}};
        vecs[5] = '{1'b0, 4'hA, 8'h5A, 1'b1, {4'hA, 8'h5A, 1'b0}};

        tick();
        tick();
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        checkOutput("reset_pc", {26'h0, pc}, 32'h0);
        checkOutput("reset_io_wren", {31'h0, io_wren}, 32'h0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].addr, vecs[i].data, vecs[i].wren);
            #1;
            checkOutput($sformatf("idle_mux_%0d", i), {19'h0, io_addr, io_wrdata, io_wren},
                        {19'h0, vecs[i].expect_io});
            tick();
        end
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0);

        // Test 1: basic list
        loadEntry(0, e_write(4'h3, 8'h10));
        loadEntry(1, e_wait(8'd100));
        loadEntry(2, e_write(4'h3, 8'h20));
        loadEntry(3, E_END);
        lst_addr = 6'd1;
        tick();
        checkOutput("list_readback", {16'h0, lst_rddata}, {16'h0, e_wait(8'd100)});
        enable = 1'b1;
        pushExpect(4'h3, 8'h10);
        pulseNewframe();
        waitCopperWrite(4, n);
        checkOutput("t1_first_write_latency", n, 2);
        vline = 8'd99;
        for (int i = 0; i < 8; i++) tick();
        checkOutput("t1_wait_pc", {26'h0, pc}, 32'd1);
        checkOutput("t1_wait_busy", {31'h0, busy}, 32'd1);
        pushExpect(4'h3, 8'h20);
        vline = 8'd100;
        tick();
        tick();
        tick();
        checkOutput("t1_second_write_timing", {31'h0, io_wren}, 32'd1);
        tick();
        waitIdle(6, n);
        checkOutput("t1_idle_after_end", {31'h0, busy}, 32'd0);
        checkOutput("t1_pc_at_end", {26'h0, pc}, 32'd3);

        // Test 2: CPU holds the bus over the copper WRITE
        vline = 8'd0;
        base = wr_count;
        applyStimulus(1'b1, 4'h0, 8'h40, 1'b0);
        pulseNewframe();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 4'(i), 8'h40 + 8'(i), i[0]);
            #1;
            checkOutput($sformatf("t2_cpu_pass_%0d", i), {19'h0, io_addr, io_wrdata, io_wren},
                        {19'h0, 4'(i), 8'h40 + 8'(i), i[0]});
            tick();
        end
        checkOutput("t2_stalled_pc", {26'h0, pc}, 32'd0);
        pushExpect(4'h3, 8'h10);
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0);
        #1;
        checkOutput("t2_copper_first_idle", {19'h0, io_addr, io_wrdata, io_wren},
                    {19'h0, 4'h3, 8'h10, 1'b1});
        tick();
        checkOutput("t2_copper_once", {31'h0, io_wren}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("t2_write_count", wr_count - base, 1);

        // Test 3: WAIT satisfied only by vblank; latched entry unaffected by list write
        enable = 1'b0;
        tick();
        checkOutput("t3_disable_idle", {31'h0, busy}, 32'd0);
        loadEntry(0, e_wait(8'd250));
        loadEntry(1, E_END);
        vline  = 8'd200;
        enable = 1'b1;
        pulseNewframe();
        for (int i = 0; i < 5; i++) tick();
        checkOutput("t3_waiting_pc", {26'h0, pc}, 32'd0);
        loadEntry(0, e_wait(8'd0));
        for (int i = 0; i < 3; i++) tick();
        checkOutput("t3_latched_copy_kept", {26'h0, pc, busy}, {26'h0, 6'd0, 1'b1});
        vline = 8'd255;
        tick();
        checkOutput("t3_vblank_advance", {26'h0, pc}, 32'd1);
        waitIdle(6, n);
        checkOutput("t3_end_idle", {26'h0, pc, busy}, {26'h0, 6'd1, 1'b0});

        // Test 4: newframe while stalled in WRITE
        loadEntry(0, e_write(4'h7, 8'h55));
        loadEntry(1, E_END);
        applyStimulus(1'b1, 4'h0, 8'h00, 1'b0);
        pulseNewframe();
        for (int i = 0; i < 4; i++) tick();
        checkOutput("t4_stalled", {26'h0, pc, busy}, {26'h0, 6'd0, 1'b1});
        pulseNewframe();
        applyStimulus(1'b0, 4'h0, 8'h00, 1'b0);
        #1;
        checkOutput("t4_write_dropped", {31'h0, io_wren}, 32'd0);
        checkOutput("t4_pc_restart", {26'h0, pc}, 32'd0);
        pushExpect(4'h7, 8'h55);
        waitCopperWrite(4, n);
        checkOutput("t4_refetch_latency", n, 2);
        tick();
        waitIdle(6, n);
        checkOutput("t4_end_idle", {26'h0, pc, busy}, {26'h0, 6'd1, 1'b0});

        // Test 5: full list without END, then enable dropped mid-list
        for (int i = 0; i < 64; i++) loadEntry(i, e_write(4'(i), 8'(i)));
        base = wr_count;
        for (int i = 0; i < 64; i++) pushExpect(4'(i), 8'(i));
        pulseNewframe();
        waitIdle(250, n);
        checkOutput("t5_all_writes", wr_count - base, 64);
        checkOutput("t5_wrap_idle", {26'h0, pc, busy}, {26'h0, 6'd63, 1'b0});
        base = wr_count;
        for (int i = 0; i < 3; i++) pushExpect(4'(i), 8'(i));
        pulseNewframe();
        waitWrites(base + 3, 40);
        enable = 1'b0;
        tick();
        checkOutput("t5_enable_low_idle", {31'h0, busy}, 32'd0);
        for (int i = 0; i < 20; i++) tick();
        enable = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checkOutput("t5_reenable_waits", {31'h0, busy}, 32'd0);
        checkOutput("t5_no_further_writes", wr_count - base, 3);
        pushExpect(4'h0, 8'h00);
        pulseNewframe();
        waitWrites(base + 4, 10);
        enable = 1'b0;
        tick();
        checkOutput("t5_restart_write", wr_count - base, 4);

        // Test 6: reset mid-WAIT
        loadEntry(0, e_wait(8'd200));
        loadEntry(1, E_END);
        vline  = 8'd0;
        enable = 1'b1;
        pulseNewframe();
        for (int i = 0; i < 5; i++) tick();
        checkOutput("t6_waiting", {31'h0, busy}, 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checkOutput("t6_reset_state", {26'h0, pc, busy}, 32'd0);
        base  = wr_count;
        vline = 8'd255;
        for (int i = 0; i < 10; i++) tick();
        checkOutput("t6_stays_idle", {31'h0, busy}, 32'd0);
        checkOutput("t6_no_writes", wr_count - base, 0);
        pulseNewframe();
        waitIdle(8, n);
        checkOutput("t6_runs_after_newframe", {26'h0, pc, busy}, {26'h0, 6'd1, 1'b0});

        checkOutput("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
